cim_edram_refresh_sched: RTL and testbench

CIM_EDRAM_REFRESH_SCHED -- requirements
Module: cim_edram_refresh_sched

---
 rtl/cim_edram_refresh_sched.sv | 129 ++++++++++++
 tb/tb_cim_edram_refresh_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cim_edram_refresh_sched.sv
// eDRAM bank access router with a credit-based, round-robin per-bank refresh scheduler.
// Build option: CIM_EDRAM_REFRESH_URGENT_EN forces refresh to start once the pending counter is full.
module cim_edram_refresh_sched #(
    parameter int REFRESH_INTERVAL = 1024,
    parameter int REFRESH_CYCLES   = 8,
    parameter int PEND_MAX         = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_addr_i,
    input  logic        req_we_i,
    output logic [15:0] bank_req_o,
    output logic [22:0] bank_addr_o,
    output logic        bank_we_o,
    output logic        err_o,
    output logic [15:0] refresh_o,
    output logic [3:0]  refresh_bank_o,
    output logic        refresh_busy_o,
    output logic        ovf_o,
    input  logic        ovf_clr_i
);
    localparam int IW  = $clog2(REFRESH_INTERVAL);
    localparam int RCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int PW  = $clog2(PEND_MAX + 1);

    typedef enum logic {IDLE, REFRESH} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  ivl_q, ivl_d;
    logic [PW-1:0]  pend_q, pend_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [3:0]     rbank_q, rbank_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    bank_req_q;
    logic [22:0]    bank_addr_q;
    logic           bank_we_q, err_q;

    logic       in_win, hit_rbank, wrap, pend_full, defer, start, ready, accept;
    logic [3:0] req_bank;

    assign in_win    = (req_addr_i[63:27] == 37'hA);
    assign req_bank  = req_addr_i[26:23];
    assign hit_rbank = req_valid_i && in_win && (req_bank == rbank_q);
    assign wrap      = (ivl_q == IW'(REFRESH_INTERVAL - 1));
    assign pend_full = (pend_q == PW'(PEND_MAX));

`ifdef CIM_EDRAM_REFRESH_URGENT_EN
    // A full credit counter overrides access priority on the next-to-refresh bank.
    assign defer = hit_rbank && !pend_full;
`else
    assign defer = hit_rbank;
`endif

    assign start  = (state_q == IDLE) && (pend_q != '0) && !defer;
    // Stall covers both an ongoing refresh and one starting this very cycle.
    assign ready  = rst_ni && !(hit_rbank && ((state_q == REFRESH) || start));
    assign accept = req_valid_i && ready;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        pend_d  = pend_q;
        ivl_d   = wrap ? '0 : ivl_q + 1'b1;
        ovf_d   = ovf_q && !ovf_clr_i;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REFRESH;
                    rcnt_d  = '0;
                end
            end
            REFRESH: begin
                if (rcnt_q == RCW'(REFRESH_CYCLES - 1)) begin
                    state_d = IDLE;
                    rbank_d = rbank_q + 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A credit arriving while one is consumed nets out to no change.
        if (wrap && !start) begin
            if (pend_full) ovf_d = 1'b1;
            else           pend_d = pend_q + 1'b1;
        end else if (!wrap && start) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ivl_q       <= '0;
            pend_q      <= '0;
            rcnt_q      <= '0;
            rbank_q     <= '0;
            ovf_q       <= 1'b0;
            bank_req_q  <= '0;
            bank_addr_q <= '0;
            bank_we_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ivl_q      <= ivl_d;
            pend_q     <= pend_d;
            rcnt_q     <= rcnt_d;
            rbank_q    <= rbank_d;
            ovf_q      <= ovf_d;
            bank_req_q <= (accept && in_win) ? (16'h1 << req_bank) : '0;
            bank_we_q  <= accept && in_win && req_we_i;
            err_q      <= accept && !in_win;
            if (accept && in_win) bank_addr_q <= req_addr_i[22:0];
        end
    end

    assign req_ready_o    = ready;
    assign bank_req_o     = bank_req_q;
    assign bank_addr_o    = bank_addr_q;
    assign bank_we_o      = bank_we_q;
    assign err_o          = err_q;
    assign refresh_busy_o = (state_q == REFRESH);
    assign refresh_o      = (state_q == REFRESH) ? (16'h1 << rbank_q) : '0;
    assign refresh_bank_o = rbank_q;
    assign ovf_o          = ovf_q;
endmodule

// File: tb/tb_cim_edram_refresh_sched.sv
// Directed bench for cim_edram_refresh_sched; access strobes are checked against a queue of expected results.
module tb_cim_edram_refresh_sched;
    localparam int RI = 16;
    localparam int RC = 4;
    localparam int PM = 2;
`ifdef CIM_EDRAM_REFRESH_URGENT_EN
    localparam bit URG = 1'b1;
`else
    localparam bit URG = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic [15:0] bank_req_o;
    logic [22:0] bank_addr_o;
    logic        bank_we_o;
    logic        err_o;
    logic [15:0] refresh_o;
    logic [3:0]  refresh_bank_o;
    logic        refresh_busy_o;
    logic        ovf_o;
    logic        ovf_clr_i = 1'b0;

    typedef struct {
        int          due;
        logic [15:0] br;
        logic [22:0] ad;
        logic        we;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    cim_edram_refresh_sched #(
        .REFRESH_INTERVAL(RI),
        .REFRESH_CYCLES  (RC),
        .PEND_MAX        (PM)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_we_i      (req_we_i),
        .bank_req_o    (bank_req_o),
        .bank_addr_o   (bank_addr_o),
        .bank_we_o     (bank_we_o),
        .err_o         (err_o),
        .refresh_o     (refresh_o),
        .refresh_bank_o(refresh_bank_o),
        .refresh_busy_o(refresh_busy_o),
        .ovf_o         (ovf_o),
        .ovf_clr_i     (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Cycle k = the period after the k-th rising edge since reset release.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic we, input logic exp_rdy);
        exp_t e;
        req_valid_i = v;
        req_addr_i  = a;
        req_we_i    = we;
        #1;
        if (v) chk("req_ready", {63'd0, req_ready_o}, {63'd0, exp_rdy});
        if (v && exp_rdy) begin
            e.due = cyc + 1;
            e.er  = (a[63:27] != 37'hA);
            e.br  = e.er ? 16'h0 : (16'h1 << a[26:23]);
            e.ad  = a[22:0];
            e.we  = we;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        while (cyc < n) tick();
    endtask

    always @(negedge clk_i) begin : mon
        exp_t e;
        if (rst_ni) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("bank_req", bank_req_o, e.br);
                chk("err", err_o, e.er);
                if (!e.er) begin
                    chk("bank_addr", bank_addr_o, e.ad);
                    chk("bank_we", bank_we_o, e.we);
                end
            end else if (bank_req_o != 16'h0 || err_o) begin
                chk("spurious_strobe", {bank_req_o, err_o}, 17'h0);
            end
            if (bank_req_o != 16'h0) chk("no_overlap", bank_req_o & refresh_o, 16'h0);
        end
    end

    initial begin
        int n;
        rst_ni = 1'b0;
        drive(1'b1, 64'h5280_0010, 1'b1, 1'b0);
        chk("rst_bank_req", bank_req_o, 16'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_refresh", refresh_o, 16'h0);
        chk("rst_rbank", refresh_bank_o, 4'd0);
        chk("rst_busy", refresh_busy_o, 1'b0);
        chk("rst_ovf", ovf_o, 1'b0);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Plain accesses, window boundaries and out-of-window errors.
        wait_cyc(2);
        drive(1'b1, 64'h5280_0010, 1'b1, 1'b1);            tick();
        drive(1'b1, 64'h5800_0000, 1'b0, 1'b1);            tick();
        drive(1'b1, 64'h4FFF_FFFC, 1'b1, 1'b1);            tick();
        drive(1'b1, 64'h57FF_FFF8, 1'b1, 1'b1);            tick();
        drive(1'b1, 64'h1_5000_0000, 1'b0, 1'b1);          tick();
        drive(1'b1, 64'h5000_0000, 1'b0, 1'b1);            tick();

        // First credit at edge 16, refresh of bank 0 over cycles 17..20.
        wait_cyc(16);
        chk("refresh_pre", refresh_o, 16'h0);
        chk("busy_pre", refresh_busy_o, 1'b0);
        wait_cyc(17);
        chk("refresh_first", refresh_o, 16'h0001);
        chk("busy_first", refresh_busy_o, 1'b1);
        wait_cyc(20);
        chk("refresh_last", refresh_o, 16'h0001);
        wait_cyc(21);
        chk("refresh_done", refresh_o, 16'h0);
        chk("rbank_adv", refresh_bank_o, 4'd1);
        chk("busy_done", refresh_busy_o, 1'b0);

        // Bank 3 refreshes over cycles 65..68: other banks pass, bank 3 stalls.
        wait_cyc(65);
        drive(1'b1, 64'h5200_0100, 1'b0, 1'b1);
        chk("refresh_b3", refresh_o, 16'h0008);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h5180_0040, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 64'h5180_0040, 1'b1, 1'b1);
        chk("rbank_after_b3", refresh_bank_o, 4'd4);
        tick();

        // Continuous requests to the next-to-refresh bank (4).
        wait_cyc(70);
        while (cyc <= 112) begin
            drive(1'b1, 64'h5200_0000 + 64'(cyc), 1'b0, !(URG && cyc >= 96 && cyc <= 100));
            if (cyc == 97) begin
                chk("busy_sat", refresh_busy_o, URG);
                chk("refresh_sat", refresh_o, URG ? 16'h0010 : 16'h0);
            end
            if (cyc == 111) chk("ovf_pre", ovf_o, 1'b0);
            if (cyc == 112) chk("ovf_sat", ovf_o, !URG);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);

        // Round-robin wrap 15 -> 0, then clear the sticky overflow.
        n = 0;
        while (refresh_bank_o !== 4'd15 && n < 600) begin tick(); n++; end
        chk("reach_bank15", refresh_bank_o, 4'd15);
        n = 0;
        while (refresh_bank_o === 4'd15 && n < 100) begin tick(); n++; end
        chk("bank_wrap", refresh_bank_o, 4'd0);
        chk("ovf_before_clr", ovf_o, !URG);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_clr", ovf_o, 1'b0);

        // Reset in the middle of a refresh aborts it without restoring the credit.
        n = 0;
        while (refresh_busy_o !== 1'b1 && n < 40) begin tick(); n++; end
        chk("busy_before_rst", refresh_busy_o, 1'b1);
        tick();
        #1;
        rst_ni = 1'b0;
        drive(1'b1, 64'h5000_0000, 1'b0, 1'b0);
        chk("abort_busy", refresh_busy_o, 1'b0);
        chk("abort_refresh", refresh_o, 16'h0);
        chk("abort_rbank", refresh_bank_o, 4'd0);
        chk("abort_ovf", ovf_o, 1'b0);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        wait_cyc(16);
        chk("no_credit_kept", refresh_o, 16'h0);
        wait_cyc(17);
        chk("refresh_after_rst", refresh_o, 16'h0001);

        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
